// File: rtl/register_file_wb.sv
// ---------------------------------------------------------------------------
// register_file_wb
//
// Architectural general-purpose register file. It is written by the
// write-back stage and read by the decode stage.
//   - Depth is 2**ADDR_WIDTH. Register $0 is hardwired to zero.
//   - There is one synchronous write port (rising edge of Clock).
//   - There are two independent combinational read ports.
//   - A retired-write counter counts architecturally effective writes,
//     which excludes writes to $0. It wraps modulo 2**CNT_WIDTH.
//
// Optional feature, selected by the macro REGFILE_WB_BYPASS_EN:
//   defined   : a read of the index being written in the same cycle returns
//               WriteData. This is an internal write-to-read bypass.
//   undefined : a read during the write cycle returns the stored (old) value.
//
// Ports:
//   Clock          in   system clock, rising-edge active
//   Reset          in   asynchronous, active-high. Clears all registers and
//                       the counter, and forces both read ports to zero.
//   RegWrite       in   write enable from write-back
//   WriteRegister  in   [ADDR_WIDTH] destination index
//   WriteData      in   [DATA_WIDTH] write-back result
//   ReadRegister1  in   [ADDR_WIDTH] read index, port 1 (rs)
//   ReadRegister2  in   [ADDR_WIDTH] read index, port 2 (rt)
//   ReadData1      out  [DATA_WIDTH] value for port 1
//   ReadData2      out  [DATA_WIDTH] value for port 2
//   WriteCount     out  [CNT_WIDTH]  effective writes since reset
// ---------------------------------------------------------------------------
module register_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [CNT_WIDTH-1:0]  WriteCount
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_eff;

  // A write is architectural only when it targets a register other than $0.
  assign wr_eff = RegWrite && (WriteRegister != '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      WriteCount <= '0;
    end else if (wr_eff) begin
      WriteCount <= WriteCount + CNT_WIDTH'(1);
    end
  end

  // Read ports. Index 0 and an active Reset always yield zero. Reset also
  // overrides the bypass, so a write still pending while Reset is held
  // cannot reach a read port.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_eff && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
`endif
    if (Reset || (ReadRegister1 == '0)) begin
      ReadData1 = '0;
    end
  end

  always_comb begin
    ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_eff && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
`endif
    if (Reset || (ReadRegister2 == '0)) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_register_file_wb.sv
// ---------------------------------------------------------------------------
// tb_register_file_wb
//
// Self-checking bench for register_file_wb. It instantiates two copies of
// the design on shared stimulus:
//   - u_dut  uses the default parameters.
//   - u_dut4 sets CNT_WIDTH = 4, so counter wrap can be observed.
// When compiled, it picks up the REGFILE_WB_BYPASS_EN setting.
// ---------------------------------------------------------------------------
module tb_register_file_wb;

  logic        Clock;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteCount;
  logic [31:0] ReadData1_4;
  logic [31:0] ReadData2_4;
  logic [3:0]  WriteCount4;

  int n_checks = 0;
  int n_errors = 0;

  register_file_wb u_dut (
    .Clock(Clock), .Reset(Reset), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteCount(WriteCount)
  );

  register_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) u_dut4 (
    .Clock(Clock), .Reset(Reset), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1_4), .ReadData2(ReadData2_4), .WriteCount(WriteCount4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] expcnt;
  } vec_t;

  vec_t vecs [8];

  // Reference model: plain array and counter, updated from the
  // architectural rules.
  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    logic [31:0] v;
    v = model_regs[idx];
    if (BYPASS && RegWrite && WriteRegister != 0 && idx == WriteRegister) v = WriteData;
    if (idx == 0) v = 32'h0;
    return v;
  endfunction

  task automatic hard_reset();
    #2 Reset = 1'b1;
    RegWrite = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd31;
    repeat (2) tick();
    Reset = 1'b0;
    #1;
    check("reset_rd1", ReadData1, 32'h0);
    check("reset_rd2", ReadData2, 32'h0);
    check("reset_cnt", WriteCount, 32'h0);

    // Preload reg 5, then assert Reset asynchronously between edges.
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF;
    tick();
    RegWrite = 1'b0;
    #1;
    check("preload_rd1", ReadData1, 32'hDEADBEEF);
    check("preload_cnt", WriteCount, 32'h1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_rd1", ReadData1, 32'h0);
    check("async_reset_cnt", WriteCount, 32'h0);
    // A write held across an edge during Reset must be lost.
    RegWrite = 1'b1; WriteRegister = 5'd6; WriteData = 32'h00000077;
    ReadRegister2 = 5'd6;
    #1;
    check("reset_bypass_rd2", ReadData2, 32'h0);
    tick();
    Reset = 1'b0;
    RegWrite = 1'b0;
    #1;
    check("reset_write_lost", ReadData2, 32'h0);
    check("reset_write_nocnt", WriteCount, 32'h0);

    // Directed table. Reads and count are checked before each edge.
    vecs[0] = '{1'b1, 5'd8,  32'h12345678, 5'd5,  5'd0, 32'h0,        32'h0,        32'd0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd8,  5'd0, 32'h12345678, 32'h0,        32'd1};
    vecs[2] = '{1'b1, 5'd3,  32'h0000000A, 5'd0,  5'd8, 32'h0,        32'h12345678, 32'd1};
    vecs[3] = '{1'b1, 5'd4,  32'h0000000B, 5'd3,  5'd0, 32'h0000000A, 32'h0,        32'd2};
    vecs[4] = '{1'b0, 5'd5,  32'h00000055, 5'd3,  5'd4, 32'h0000000A, 32'h0000000B, 32'd3};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd4, 32'h0000000B, 32'h0000000B, 32'd3};
    vecs[6] = '{1'b1, 5'd31, 32'h00000001, 5'd5,  5'd8, 32'h0,        32'h12345678, 32'd3};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3, 32'h00000001, 32'h0000000A, 32'd4};
    for (int i = 0; i < 8; i++) begin
      RegWrite = vecs[i].we; WriteRegister = vecs[i].waddr; WriteData = vecs[i].wdata;
      ReadRegister1 = vecs[i].ra1; ReadRegister2 = vecs[i].ra2;
      #2;
      check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].exp2);
      check($sformatf("vec%0d_cnt", i), WriteCount, vecs[i].expcnt);
      tick();
    end

    // Same-cycle read and write of reg 31 (old 0x1, new 0x2).
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 32'h2;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #2;
    check("rw31_same_cycle_rd1", ReadData1, BYPASS ? 32'h2 : 32'h1);
    check("rw31_same_cycle_rd2", ReadData2, BYPASS ? 32'h2 : 32'h1);
    tick();
    RegWrite = 1'b0;
    #2;
    check("rw31_next_cycle", ReadData1, 32'h2);
    check("rw31_cnt", WriteCount, 32'd5);

    // Counter wrap on the 4-bit instance. RegWrite=0 cycles are interleaved.
    hard_reset();
    check("wrap_reset_cnt4", {28'h0, WriteCount4}, 32'h0);
    for (int i = 0; i < 17; i++) begin
      RegWrite = 1'b1; WriteRegister = 5'((i % 31) + 1); WriteData = 32'(i);
      tick();
      RegWrite = 1'b0; WriteRegister = 5'd0;
      tick();
      if (i == 15) check("wrap_16_cnt4", {28'h0, WriteCount4}, 32'h0);
    end
    check("wrap_17_cnt4", {28'h0, WriteCount4}, 32'h1);
    check("wrap_17_cnt32", WriteCount, 32'd17);

    // Randomized run against the reference model.
    hard_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
    for (int n = 0; n < 400; n++) begin
      RegWrite = 1'($urandom_range(0, 1));
      WriteRegister = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      WriteData = $urandom;
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = ($urandom_range(0, 1) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      #2;
      check("rand_rd1", ReadData1, model_read(ReadRegister1));
      check("rand_rd2", ReadData2, model_read(ReadRegister2));
      check("rand_cnt", WriteCount, model_cnt);
      check("rand_cnt4", {28'h0, WriteCount4}, {28'h0, model_cnt[3:0]});
      if (RegWrite && WriteRegister != 0) begin
        model_regs[WriteRegister] = WriteData;
        model_cnt = model_cnt + 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
